// File: rtl/multiplier_64b_arb_pkg.sv
// Shared types and default constants for the shared-multiplier arbiter.
package multiplier_64b_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam int MUL_DATA_W  = 64;
   localparam int MUL_LATENCY = 1;

endpackage

// File: rtl/multiplier_64b_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from ptr+1 (mod N) and returns
// a one-hot grant plus its encoded index.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             en,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic found;
   int   cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = 0;
      for (int k = 1; k <= N; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N) cand = cand - N;
         if (en && !found && req[cand]) begin
            gnt[cand] = 1'b1;
            gnt_idx   = IDX_W'(cand);
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/multiplier_64b_arbiter.sv
// Shares one registered multiplier between N requesters: round-robin accept,
// drive the multiplier for LATENCY cycles, then hold the product on a response.
module multiplier_64b_arbiter
   import multiplier_64b_arb_pkg::*;
#(
   parameter int N       = 4,
   parameter int DATA_W  = MUL_DATA_W,
   parameter int LATENCY = MUL_LATENCY
) (
   input  logic                   iClk,
   input  logic                   iRstN,
   input  logic [N-1:0]           iReqValid,
   input  logic [N*DATA_W-1:0]    iReqData0,
   input  logic [N*DATA_W-1:0]    iReqData1,
   output logic [N-1:0]           oReqReady,
   output logic                   oMulEn,
   output logic                   oMulClr,
   output logic [DATA_W-1:0]      oMulData0,
   output logic [DATA_W-1:0]      oMulData1,
   input  logic [2*DATA_W-1:0]    iMulData,
   output logic                   oRspValid,
   input  logic                   iRspReady,
   output logic [$clog2(N)-1:0]   oRspId,
   output logic [2*DATA_W-1:0]    oRspData,
   output logic                   oBusy
);

   localparam int IDX_W = $clog2(N);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   arb_state_t       state, state_nxt;
   logic [IDX_W-1:0] ptr;
   logic [CNT_W-1:0] cnt;
   logic [N-1:0]     gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             accept;

   // Gating with iRstN keeps the grant low while reset is held.
   rr_arbiter #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req     (iReqValid),
      .ptr     (ptr),
      .en      ((state == IDLE) && iRstN),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign accept    = |gnt;
   assign oReqReady = gnt;
   assign oMulEn    = (state == EXEC);
   assign oRspValid = (state == RESP);
   assign oBusy     = (state != IDLE);
   assign oRspData  = oRspValid ? iMulData : '0;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    if (cnt == '0) state_nxt = RESP;
         RESP:    if (iRspReady) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state     <= IDLE;
         ptr       <= IDX_W'(N - 1);
         cnt       <= '0;
         oMulData0 <= '0;
         oMulData1 <= '0;
         oRspId    <= '0;
         oMulClr   <= 1'b0;
      end else begin
         state   <= state_nxt;
         // Clear lands in the IDLE cycle after the handshake, when oMulEn is 0.
         oMulClr <= (state == RESP) && iRspReady;
         if (accept) begin
            oMulData0 <= iReqData0[int'(gnt_idx)*DATA_W +: DATA_W];
            oMulData1 <= iReqData1[int'(gnt_idx)*DATA_W +: DATA_W];
            oRspId    <= gnt_idx;
            ptr       <= gnt_idx;
            cnt       <= CNT_W'(LATENCY - 1);
         end else if ((state == EXEC) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_multiplier_64b_arbiter.sv
// Bench for multiplier_64b_arbiter with behavioural 1- and 3-stage multipliers
// and a scoreboard of expected (id, product) pairs.
module tb_multiplier_64b_arbiter;

   localparam int N = 4;
   localparam int W = 64;

   typedef struct {
      logic [1:0]   id;
      logic [127:0] prod;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [W-1:0]   a_op [N];
   logic [W-1:0]   b_op [N];
   logic [N*W-1:0] req_data0, req_data1;
   logic [N-1:0]   req_ready;
   logic           mul_en, mul_clr, rsp_valid, rsp_ready, busy;
   logic [W-1:0]   mul_data0, mul_data1;
   logic [127:0]   mul_q, rsp_data;
   logic [1:0]     rsp_id;

   logic [N-1:0]   req_valid3, req_ready3;
   logic [N*W-1:0] d3_a, d3_b;
   logic           mul_en3, mul_clr3, rsp_valid3, rsp_ready3, busy3;
   logic [W-1:0]   mul3_d0, mul3_d1;
   logic [127:0]   mul3_q, rsp_data3;
   logic [1:0]     rsp_id3;
   logic [127:0]   s3 [3];

   exp_t sb [$];
   int   checks = 0;
   int   errors = 0;

   assign req_data0 = {a_op[3], a_op[2], a_op[1], a_op[0]};
   assign req_data1 = {b_op[3], b_op[2], b_op[1], b_op[0]};

   multiplier_64b_arbiter #(.N(N), .DATA_W(W), .LATENCY(1)) dut (
      .iClk(clk), .iRstN(rst_n), .iReqValid(req_valid), .iReqData0(req_data0),
      .iReqData1(req_data1), .oReqReady(req_ready), .oMulEn(mul_en), .oMulClr(mul_clr),
      .oMulData0(mul_data0), .oMulData1(mul_data1), .iMulData(mul_q),
      .oRspValid(rsp_valid), .iRspReady(rsp_ready), .oRspId(rsp_id),
      .oRspData(rsp_data), .oBusy(busy)
   );

   multiplier_64b_arbiter #(.N(N), .DATA_W(W), .LATENCY(3)) dut3 (
      .iClk(clk), .iRstN(rst_n), .iReqValid(req_valid3), .iReqData0(d3_a),
      .iReqData1(d3_b), .oReqReady(req_ready3), .oMulEn(mul_en3), .oMulClr(mul_clr3),
      .oMulData0(mul3_d0), .oMulData1(mul3_d1), .iMulData(mul3_q),
      .oRspValid(rsp_valid3), .iRspReady(rsp_ready3), .oRspId(rsp_id3),
      .oRspData(rsp_data3), .oBusy(busy3)
   );

   // Behavioural multiplier_64b_reg models: product advances only while enabled.
   always @(posedge clk) begin
      if (mul_clr) mul_q <= '0;
      else if (mul_en) mul_q <= {64'b0, mul_data0} * {64'b0, mul_data1};
   end

   always @(posedge clk) begin
      if (mul_clr3) begin
         s3[0] <= '0; s3[1] <= '0; s3[2] <= '0;
      end else if (mul_en3) begin
         s3[0] <= {64'b0, mul3_d0} * {64'b0, mul3_d1};
         s3[1] <= s3[0];
         s3[2] <= s3[1];
      end
   end
   assign mul3_q = s3[2];

   // Scoreboard: push on accept, pop on response handshake.
   always @(negedge clk) begin : monitor
      exp_t e;
      int   g;
      if (rst_n) begin
         if (req_ready != '0) begin
            checks++;
            if (!$onehot(req_ready)) begin
               errors++;
               $display("FAIL onehot_grant: got %b required one-hot", req_ready);
            end
            g = 0;
            for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
            e.id   = 2'(g);
            e.prod = {64'b0, a_op[g]} * {64'b0, b_op[g]};
            sb.push_back(e);
         end
         if (rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected_rsp: got id %0d with no pending request", rsp_id);
            end else begin
               e = sb.pop_front();
               checks++;
               if (rsp_id !== e.id) begin
                  errors++;
                  $display("FAIL sb_id: got %0d required %0d", rsp_id, e.id);
               end
               checks++;
               if (rsp_data !== e.prod) begin
                  errors++;
                  $display("FAIL sb_data: got %h required %h", rsp_data, e.prod);
               end
            end
         end
      end
   end

   always @(negedge rst_n) sb.delete();

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = '1;
      req_valid3 = '1;
      @(negedge clk);
      checks++;
      if ({req_ready, req_ready3} !== 8'h00) begin
         errors++;
         $display("FAIL reset_ready: got %b %b required 0", req_ready, req_ready3);
      end
      checks++;
      if ({mul_en, mul_clr, rsp_valid, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 0000", {mul_en, mul_clr, rsp_valid, busy});
      end
      checks++;
      if ({mul_data0, mul_data1, rsp_id, rsp_data} !== '0) begin
         errors++;
         $display("FAIL reset_data: got %h %h %0d %h required 0", mul_data0, mul_data1, rsp_id, rsp_data);
      end
      req_valid = '0;
      req_valid3 = '0;
      do_reset();
   endtask

   task automatic test_single();
      a_op[2] = 64'd3; b_op[2] = 64'd5;
      req_valid = 4'b0100; rsp_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL single_grant: got %b required 0100", req_ready);
      end
      step();
      req_valid = '0; rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({mul_en, rsp_valid, busy} !== 3'b101) begin
         errors++; $display("FAIL single_exec: got %b required 101", {mul_en, rsp_valid, busy});
      end
      step();
      @(negedge clk);
      checks++;
      if ({rsp_valid, mul_en, rsp_id, rsp_data} !== {1'b1, 1'b0, 2'd2, 128'd15}) begin
         errors++; $display("FAIL single_rsp: got v=%b en=%b id=%0d d=%0d required 1 0 2 15", rsp_valid, mul_en, rsp_id, rsp_data);
      end
      step();
      @(negedge clk);
      checks++;
      if ({mul_clr, busy, rsp_valid} !== 3'b100) begin
         errors++; $display("FAIL single_clr_on: got %b required 100", {mul_clr, busy, rsp_valid});
      end
      step();
      @(negedge clk);
      checks++;
      if (mul_clr !== 1'b0) begin
         errors++; $display("FAIL single_clr_off: got %b required 0", mul_clr);
      end
      step();
   endtask

   task automatic test_full_width();
      a_op[1] = '1; b_op[1] = '1;
      req_valid = 4'b0010; rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++; $display("FAIL full_grant: got %b required 0010", req_ready);
      end
      step();
      req_valid = '0;
      step();
      @(negedge clk);
      checks++;
      if (rsp_data !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001 || rsp_valid !== 1'b1) begin
         errors++; $display("FAIL full_data: got v=%b %h required 1 fffffffffffffffe0000000000000001", rsp_valid, rsp_data);
      end
      step();
      step();
   endtask

   task automatic test_fairness();
      logic [3:0] exp;
      req_valid = '0;
      do_reset();
      for (int i = 0; i < N; i++) begin
         a_op[i] = 64'(10 + i);
         b_op[i] = 64'(100 * i + 1);
      end
      req_valid = '1; rsp_ready = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         exp = (c % 3 == 0) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
         checks++;
         if (req_ready !== exp) begin
            errors++; $display("FAIL fair_cycle%0d: got %b required %b", c, req_ready, exp);
         end
         step();
      end
      req_valid = '0;
      step();
   endtask

   task automatic test_backpressure();
      logic [127:0] exp;
      a_op[3] = 64'd123456789; b_op[3] = 64'd987654321;
      exp = 128'd123456789 * 128'd987654321;
      req_valid = 4'b1000; rsp_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++; $display("FAIL bp_grant: got %b required 1000", req_ready);
      end
      step();
      req_valid = '1;
      step();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if ({rsp_valid, rsp_id, rsp_data, req_ready, mul_en} !== {1'b1, 2'd3, exp, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL bp_hold%0d: got v=%b id=%0d d=%h rdy=%b en=%b required 1 3 %h 0000 0", c, rsp_valid, rsp_id, rsp_data, req_ready, mul_en, exp);
         end
         step();
      end
      rsp_ready = 1'b1; req_valid = '0;
      step();
      @(negedge clk);
      checks++;
      if ({mul_clr, rsp_valid} !== 2'b10) begin
         errors++; $display("FAIL bp_release: got %b required 10", {mul_clr, rsp_valid});
      end
      step();
   endtask

   task automatic test_reset_mid();
      a_op[1] = 64'd11; b_op[1] = 64'd13;
      req_valid = 4'b0010; rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++; $display("FAIL rstmid_grant: got %b required 0010", req_ready);
      end
      step();
      req_valid = '1;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({mul_en, rsp_valid, busy, mul_clr, req_ready} !== 8'h00 ||
          {mul_data0, mul_data1, rsp_id, rsp_data} !== '0) begin
         errors++;
         $display("FAIL rstmid_async: got en=%b v=%b busy=%b rdy=%b d0=%h id=%0d required all 0", mul_en, rsp_valid, busy, req_ready, mul_data0, rsp_id);
      end
      step();
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL rstmid_first_grant: got %b required 0001", req_ready);
      end
      step();
      req_valid = '0;
      step();
      step();
      step();
   endtask

   task automatic test_latency3();
      d3_a = '0; d3_b = '0;
      d3_a[W-1:0] = 64'd7; d3_b[W-1:0] = 64'd9;
      req_valid3 = 4'b0001; rsp_ready3 = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready3 !== 4'b0001) begin
         errors++; $display("FAIL lat3_grant: got %b required 0001", req_ready3);
      end
      step();
      req_valid3 = '0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         checks++;
         if ({mul_en3, rsp_valid3} !== 2'b10) begin
            errors++; $display("FAIL lat3_exec%0d: got en=%b v=%b required 1 0", k, mul_en3, rsp_valid3);
         end
         step();
      end
      @(negedge clk);
      checks++;
      if ({rsp_valid3, mul_en3, rsp_id3, rsp_data3} !== {1'b1, 1'b0, 2'd0, 128'd63}) begin
         errors++; $display("FAIL lat3_rsp: got v=%b en=%b id=%0d d=%0d required 1 0 0 63", rsp_valid3, mul_en3, rsp_id3, rsp_data3);
      end
      step();
      @(negedge clk);
      checks++;
      if (mul_clr3 !== 1'b1) begin
         errors++; $display("FAIL lat3_clr: got %b required 1", mul_clr3);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int budget;
      for (int c = 0; c < 300; c++) begin
         req_valid = 4'($urandom_range(0, 15));
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) begin
               a_op[i] = '1; b_op[i] = '1;
            end else begin
               a_op[i] = {$urandom, $urandom};
               b_op[i] = {$urandom, $urandom};
            end
         end
         step();
      end
      req_valid = '0; rsp_ready = 1'b1;
      budget = 0;
      while ((sb.size() != 0 || busy) && budget < 20) begin
         step();
         budget++;
      end
      @(negedge clk);
      checks++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL drain: got %0d pending busy=%b required 0 0", sb.size(), busy);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = '0; rsp_ready = 1'b0;
      req_valid3 = '0; rsp_ready3 = 1'b0;
      d3_a = '0; d3_b = '0;
      for (int i = 0; i < N; i++) begin
         a_op[i] = '0; b_op[i] = '0;
      end
      step();
      test_reset();
      test_single();
      test_full_width();
      test_fairness();
      test_backpressure();
      test_reset_mid();
      test_latency3();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multiplier_64b_arbiter.md
# multiplier_64b_arbiter

- Shares one registered 64×64 multiplier (`multiplier_64b_reg`) between N requesters.
- Round-robin arbitration; each request is a valid/ready handshake.
- Drives the multiplier's enable, clear and operand ports, then returns the 128-bit product with the winner's ID over a valid/ready response channel.
- Sits between the requesting engines and the multiplier instance; non-pipelined, one operation in flight.

## Interface
- `N`, 4, number of requesters (≥2).
- `DATA_W`, 64, operand width; product is 2·DATA_W.
- `LATENCY`, 1, multiplier register stages from enabled operands to valid `iMulData`.
- `iClk  in  1  clock; all logic on rising edge`
- `iRstN  in  1  reset; asynchronous, active-low`
- `iReqValid  in  N  per-requester request valid`
- `iReqData0  in  N×DATA_W  packed operand A, requester i at [i*DATA_W +: DATA_W]`
- `iReqData1  in  N×DATA_W  packed operand B, same packing`
- `oReqReady  out  N  one-hot grant/accept, at most one bit high`
- `oMulEn  out  1  multiplier enable`
- `oMulClr  out  1  multiplier synchronous clear`
- `oMulData0  out  DATA_W  registered operand A to multiplier`
- `oMulData1  out  DATA_W  registered operand B to multiplier`
- `iMulData  in  2·DATA_W  multiplier product`
- `oRspValid  out  1  response valid`
- `iRspReady  in  1  response accepted by consumer`
- `oRspId  out  $clog2(N)  requester index of the response`
- `oRspData  out  2·DATA_W  product; equals iMulData while oRspValid`
- `oBusy  out  1  high in EXEC or RESP`

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Round-robin search starts at `ptr+1` (mod N) and picks the first requester with `iReqValid` set.
  - `oReqReady[g]` is driven combinationally high for the winner `g`; this is the accept cycle.
  - On accept: latch `iReqData0/1[g]` into `oMulData0/1`, latch `g` into `oRspId`, set `ptr <= g`, set `cnt <= LATENCY-1`, go to EXEC.
  - No valid requests: stay in IDLE with all `oReqReady` low.
- **EXEC**
  - `oMulEn=1`; operands held stable.
  - When `cnt==0`, go to RESP; otherwise decrement `cnt`.
- **RESP**
  - `oMulEn=0`, so the multiplier holds its result.
  - `oRspValid=1`; `oRspData=iMulData`.
  - On `iRspReady`: go to IDLE and register `oMulClr=1` for exactly one cycle.
  - Without `iRspReady`: hold `oRspValid`, `oRspId` and data indefinitely.
- **Multiplier clear**
  - `oMulClr` is only ever high during the IDLE cycle that follows a response handshake.
  - A new request may be accepted in that same cycle. This is legal because `oMulEn` is 0 in IDLE.
- **Deassertion**
  - A requester may drop `iReqValid` in any cycle without being granted.
  - Once granted, its operands are already captured.
- **Reset** (any time, including mid-EXEC or mid-RESP)
  - State returns to IDLE.
  - `ptr=N-1`, so requester 0 has first priority.
  - `cnt=0`; `oMulData0/1=0`; `oRspId=0`; `oMulClr=0`.
  - All combinational outputs are low.
  - An in-flight operation is dropped; no response is issued.

## Timing
- Accept in cycle T:
  - `oMulEn` is high in cycles T+1 … T+LATENCY.
  - `oRspValid` first rises in cycle T+LATENCY+1; for LATENCY=1, that is T+2.
- Minimum issue interval is LATENCY+2 cycles (accept, EXEC, RESP with immediate ready).
  - The next accept can occur in the cycle after the handshake.
- `oReqReady` and `oRspData` are combinational; all other outputs are registered.
- `oReqReady` depends on `iReqValid`, so requesters must not derive `iReqValid` from `oReqReady`.
- Fairness: with all N requesting continuously, grants rotate 0,1,…,N-1,0.
  - No requester waits more than N-1 grants.

## Structure
- Package `multiplier_64b_arb_pkg` holds:
  - state enum `arb_state_t` (IDLE, EXEC, RESP);
  - default constants `MUL_DATA_W=64` and `MUL_LATENCY=1`.
- Sub-module `rr_arbiter`:
  - parameterised by N;
  - inputs: `req`, `ptr`, `en`;
  - outputs: one-hot `gnt` and encoded `gnt_idx`;
  - purely combinational.
- The multiplier is not instantiated inside. The bench connects `multiplier_64b_reg` via `oMulEn`/`oMulClr`/`oMulData*`/`iMulData`.

## Test plan
- **Single request:** reset, requester 2 with A=3, B=5.
  - `oReqReady=4'b0100` in the accept cycle.
  - Two cycles later: `oRspValid=1`, `oRspId=2`, `oRspData=15`.
  - `oMulClr` pulses once after `iRspReady`.
- **Full width:** A=B=64'hFFFF_FFFF_FFFF_FFFF.
  - `oRspData=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001`.
- **Fairness:** all 4 requesters valid continuously, `iRspReady=1`.
  - Grant order 0,1,2,3,0.
  - A new accept every 3 cycles with LATENCY=1.
- **Backpressure:** hold `iRspReady=0` for 10 cycles during RESP.
  - `oRspValid`, `oRspId` and `oRspData` stay stable.
  - No `oReqReady` is asserted; `oMulEn=0` throughout.
- **Reset mid-operation:** assert `iRstN=0` during EXEC.
  - All outputs are 0 immediately (asynchronous).
  - After release with all requesting, the first grant goes to requester 0.
- **Latency parameter:** LATENCY=3 with a 3-stage multiplier model, A=7, B=9.
  - `oMulEn` is high for 3 cycles.
  - `oRspValid` appears at T+4 with `oRspData=63`.
